// File: rtl/traffic_phase_scheduler.sv
// Two-approach actuated intersection controller: main road rests in green, side road
// is served on latched vehicle/pedestrian requests, emergency preempt returns to main.
module traffic_phase_scheduler #(
  parameter int MAIN_MIN = 20,
  parameter int SIDE_MIN = 10,
  parameter int YELLOW_T = 2,
  parameter int ALLRED_T = 1,
  parameter int WALK_T   = 10,
  parameter int BLINK_T  = 4,
  parameter int CNT_W    = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       car_side_req,
  input  logic       ped_side_req,
  input  logic       emerg,
  output logic [1:0] main_car,
  output logic [1:0] side_car,
  output logic [1:0] main_hmn,
  output logic [1:0] side_hmn,
  output logic [2:0] phase,
  output logic       req_pending
);

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_A   = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALL_RED_B   = 3'd5
  } state_t;

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] GREEN  = 2'b01;
  localparam logic [1:0] YELLOW = 2'b10;
  localparam logic [1:0] BLINK  = 2'b10;

  localparam int WB       = WALK_T + BLINK_T;
  localparam int SIDE_LEN = (SIDE_MIN > WB) ? SIDE_MIN : WB;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             car_l, ped_l, walk_en;
  logic             enter_side;
  logic [CNT_W-1:0] side_last;

  function automatic logic [1:0] walk_head(input logic [CNT_W-1:0] c);
    if (c < CNT_W'(WALK_T))  return GREEN;
    else if (c < CNT_W'(WB)) return BLINK;
    else                     return RED;
  endfunction

  assign side_last  = walk_en ? CNT_W'(SIDE_LEN - 1) : CNT_W'(SIDE_MIN - 1);
  assign enter_side = (state_nxt == SIDE_GREEN) && (state != SIDE_GREEN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= MAIN_GREEN;
      cnt     <= '0;
      car_l   <= 1'b0;
      ped_l   <= 1'b0;
      walk_en <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) cnt <= '0;
      else if (cnt != '1)     cnt <= cnt + CNT_W'(1);
      // A request sampled on the clearing edge survives: set wins over clear.
      car_l <= (car_side_req && (state != SIDE_GREEN)) || (car_l && !enter_side);
      ped_l <= ped_side_req || (ped_l && !enter_side);
      if (enter_side) walk_en <= ped_l;
    end
  end

  always_comb begin
    state_nxt = state;
    main_car  = RED;
    side_car  = RED;
    main_hmn  = RED;
    side_hmn  = RED;
    unique case (state)
      MAIN_GREEN: begin
        main_car = GREEN;
        main_hmn = walk_head(cnt);
        if ((cnt >= CNT_W'(MAIN_MIN - 1)) && (car_l || ped_l) && !emerg)
          state_nxt = MAIN_YELLOW;
      end
      MAIN_YELLOW: begin
        main_car = YELLOW;
        if (cnt >= CNT_W'(YELLOW_T - 1)) state_nxt = ALL_RED_A;
      end
      ALL_RED_A: begin
        if (cnt >= CNT_W'(ALLRED_T - 1)) state_nxt = emerg ? MAIN_GREEN : SIDE_GREEN;
      end
      SIDE_GREEN: begin
        side_car = GREEN;
        // Preempt darkens the walk at once rather than waiting for the edge.
        if (walk_en && !emerg) side_hmn = walk_head(cnt);
        if (emerg || (cnt >= side_last)) state_nxt = SIDE_YELLOW;
      end
      SIDE_YELLOW: begin
        side_car = YELLOW;
        if (cnt >= CNT_W'(YELLOW_T - 1)) state_nxt = ALL_RED_B;
      end
      ALL_RED_B: begin
        if (cnt >= CNT_W'(ALLRED_T - 1)) state_nxt = MAIN_GREEN;
      end
      default: state_nxt = MAIN_GREEN;
    endcase
  end

  assign phase       = state;
  assign req_pending = car_l || ped_l;

endmodule
